// File: rtl/senoide_pkg.sv
// Shared definitions for the sine generator / detector pair: sample width,
// default mid-scale and hysteresis codes, and the detector FSM encoding.
package senoide_pkg;

    localparam int LARG_AMOSTRA     = 8;
    localparam int MEIO_PADRAO      = 128;
    localparam int HIST_PADRAO      = 8;
    localparam int LARG_CONT_PADRAO = 16;

    typedef enum logic [1:0] {
        BUSCA    = 2'd0,
        PRIMEIRO = 2'd1,
        MEDINDO  = 2'd2
    } estado_det_t;

endpackage

// File: rtl/detector_senoide_if.sv
// Sample and recovered-bit bus of detector_senoide.
// Optional `pico` signal exists only with DETECTOR_SENOIDE_AMPLITUDE_EN defined.
interface detector_senoide_if import senoide_pkg::*; #(
    parameter int LARG_CONT = LARG_CONT_PADRAO
) ();

    // amostra is consumed on every clock where amostra_valida=1; there is no
    // ready/backpressure. dado_valido is a one-cycle pulse qualifying
    // dado_periodo/periodo; the consumer must take it in that cycle.
    logic [LARG_AMOSTRA-1:0] amostra;
    logic                    amostra_valida;
    logic                    dado_rec;
    logic                    dado_valido;
    logic                    dado_periodo;
    logic [LARG_CONT-1:0]    periodo;
    logic                    travado;
    logic                    sem_sinal;
    estado_det_t             estado;
`ifdef DETECTOR_SENOIDE_AMPLITUDE_EN
    logic [LARG_AMOSTRA-1:0] pico;

    modport master (
        output amostra, amostra_valida,
        input  dado_rec, dado_valido, dado_periodo, periodo, travado, sem_sinal, estado, pico
    );
    modport slave (
        input  amostra, amostra_valida,
        output dado_rec, dado_valido, dado_periodo, periodo, travado, sem_sinal, estado, pico
    );
`else
    modport master (
        output amostra, amostra_valida,
        input  dado_rec, dado_valido, dado_periodo, periodo, travado, sem_sinal, estado
    );
    modport slave (
        input  amostra, amostra_valida,
        output dado_rec, dado_valido, dado_periodo, periodo, travado, sem_sinal, estado
    );
`endif

endinterface

// File: rtl/detector_cruzamento.sv
// Registers the incoming sample and flags rising mid-scale crossings with
// hysteresis. Extra sample outputs exist only with DETECTOR_SENOIDE_AMPLITUDE_EN.
module detector_cruzamento import senoide_pkg::*; #(
    parameter int MEIO = MEIO_PADRAO,
    parameter int HIST = HIST_PADRAO
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LARG_AMOSTRA-1:0] amostra,
    input  logic                    amostra_valida,
    output logic                    ev
`ifdef DETECTOR_SENOIDE_AMPLITUDE_EN
    ,
    output logic [LARG_AMOSTRA-1:0] amostra_reg,
    output logic                    valida_reg
`endif
);

    localparam logic [LARG_AMOSTRA-1:0] LIM_BAIXO = LARG_AMOSTRA'(MEIO - HIST);
    localparam logic [LARG_AMOSTRA-1:0] LIM_ALTO  = LARG_AMOSTRA'(MEIO + HIST);

    logic [LARG_AMOSTRA-1:0] amostra_q;
    logic                    valida_q;
    logic                    armado;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amostra_q <= '0;
            valida_q  <= 1'b0;
        end else begin
            amostra_q <= amostra;
            valida_q  <= amostra_valida;
        end
    end

    // Arming below the low threshold and firing above the high one means
    // samples inside the hysteresis band can never produce a second event.
    assign ev = armado && valida_q && (amostra_q >= LIM_ALTO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armado <= 1'b0;
        end else if (ev) begin
            armado <= 1'b0;
        end else if (valida_q && (amostra_q < LIM_BAIXO)) begin
            armado <= 1'b1;
        end
    end

`ifdef DETECTOR_SENOIDE_AMPLITUDE_EN
    assign amostra_reg = amostra_q;
    assign valida_reg  = valida_q;
`endif

endmodule

// File: rtl/detector_senoide.sv
// FSK receiver: measures the period between rising crossings, classifies it
// and debounces the recovered bit. Optional peak output: DETECTOR_SENOIDE_AMPLITUDE_EN.
module detector_senoide import senoide_pkg::*; #(
    parameter int MEIO           = MEIO_PADRAO,
    parameter int HIST           = HIST_PADRAO,
    parameter int LIMIAR_PERIODO = 192,
    parameter int PERIODO_MAX    = 4096,
    parameter int CONFIRMA       = 2,
    parameter int LARG_CONT      = LARG_CONT_PADRAO
) (
    input  logic         CLOCK_50,
    input  logic         resetTop,
    detector_senoide_if.slave bus
);

    localparam int                   LARG_CONF = $clog2(CONFIRMA + 1);
    localparam logic [LARG_CONF-1:0] CONF_ALVO = LARG_CONF'(CONFIRMA);
    localparam logic [LARG_CONT-1:0] CONT_MAX  = '1;
    localparam logic [LARG_CONT-1:0] LIM_PERDA = LARG_CONT'(PERIODO_MAX);
    localparam logic [LARG_CONT-1:0] LIMIAR    = LARG_CONT'(LIMIAR_PERIODO);

    logic                 ev;
    logic [LARG_CONT-1:0] cont;
    estado_det_t          estado, estado_prox;
    logic                 reporta, perda;
    logic                 classe;
    logic [LARG_CONF-1:0] conf, conf_prox;
    logic                 ultima;
    logic                 dado_rec_q, dado_valido_q, dado_periodo_q;
    logic [LARG_CONT-1:0] periodo_q;

`ifdef DETECTOR_SENOIDE_AMPLITUDE_EN
    logic [LARG_AMOSTRA-1:0] amostra_reg, maximo, pico_q;
    logic                    valida_reg;
`endif

    detector_cruzamento #(
        .MEIO (MEIO),
        .HIST (HIST)
    ) u_cruzamento (
        .clk            (CLOCK_50),
        .rst            (resetTop),
        .amostra        (bus.amostra),
        .amostra_valida (bus.amostra_valida),
        .ev             (ev)
`ifdef DETECTOR_SENOIDE_AMPLITUDE_EN
        ,
        .amostra_reg    (amostra_reg),
        .valida_reg     (valida_reg)
`endif
    );

    // Loading 1 on the event makes the count at the next event equal the
    // number of clocks between the two crossings.
    always_ff @(posedge CLOCK_50 or posedge resetTop) begin
        if (resetTop) begin
            cont <= '0;
        end else if (ev) begin
            cont <= LARG_CONT'(1);
        end else if (cont != CONT_MAX) begin
            cont <= cont + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge resetTop) begin
        if (resetTop) estado <= BUSCA;
        else          estado <= estado_prox;
    end

    // An event in the same cycle as the timeout takes priority.
    always_comb begin
        estado_prox = estado;
        reporta     = 1'b0;
        perda       = 1'b0;
        unique case (estado)
            BUSCA: begin
                if (ev) estado_prox = PRIMEIRO;
            end
            PRIMEIRO, MEDINDO: begin
                if (ev) begin
                    reporta     = 1'b1;
                    estado_prox = MEDINDO;
                end else if (cont >= LIM_PERDA) begin
                    perda       = 1'b1;
                    estado_prox = BUSCA;
                end
            end
            default: estado_prox = BUSCA;
        endcase
    end

    always_comb begin
        classe = (cont < LIMIAR);
        if (classe != ultima) conf_prox = LARG_CONF'(1);
        else if (conf >= CONF_ALVO) conf_prox = conf;
        else conf_prox = conf + 1'b1;
    end

    always_ff @(posedge CLOCK_50 or posedge resetTop) begin
        if (resetTop) begin
            dado_valido_q  <= 1'b0;
            dado_periodo_q <= 1'b0;
            periodo_q      <= '0;
            dado_rec_q     <= 1'b0;
            conf           <= '0;
            ultima         <= 1'b0;
        end else begin
            dado_valido_q <= reporta;
            if (reporta) begin
                periodo_q      <= cont;
                dado_periodo_q <= classe;
                ultima         <= classe;
                conf           <= conf_prox;
                if ((conf_prox >= CONF_ALVO) && (classe != dado_rec_q)) begin
                    dado_rec_q <= classe;
                end
            end else if (perda) begin
                conf <= '0;
            end
        end
    end

`ifdef DETECTOR_SENOIDE_AMPLITUDE_EN
    // Running maximum restarts at the crossing sample; its value at the next
    // crossing covers exactly one complete period.
    always_ff @(posedge CLOCK_50 or posedge resetTop) begin
        if (resetTop) begin
            maximo <= '0;
            pico_q <= '0;
        end else begin
            if (ev) maximo <= amostra_reg;
            else if (valida_reg && (amostra_reg > maximo)) maximo <= amostra_reg;
            if (reporta) pico_q <= maximo;
        end
    end

    assign bus.pico = pico_q;
`endif

    assign bus.dado_rec     = dado_rec_q;
    assign bus.dado_valido  = dado_valido_q;
    assign bus.dado_periodo = dado_periodo_q;
    assign bus.periodo      = periodo_q;
    assign bus.travado      = (estado == MEDINDO);
    assign bus.sem_sinal    = (estado != MEDINDO);
    assign bus.estado       = estado;

endmodule

// File: tb/tb_detector_senoide.sv
// Randomized triangle-wave bench for detector_senoide with an event-time
// reference model feeding an expected-report queue.
module tb_detector_senoide;
  import senoide_pkg::*;

  localparam int LARG_CONT = 16;
  localparam int MEIO      = 128;
  localparam int HIST      = 8;
  localparam int LIMIAR    = 192;
  localparam int PMAX      = 4096;
  localparam int CONFIRMA  = 2;

  logic CLOCK_50 = 1'b0;
  logic resetTop;

  detector_senoide_if #(.LARG_CONT(LARG_CONT)) bus ();

  detector_senoide #(
    .MEIO           (MEIO),
    .HIST           (HIST),
    .LIMIAR_PERIODO (LIMIAR),
    .PERIODO_MAX    (PMAX),
    .CONFIRMA       (CONFIRMA),
    .LARG_CONT      (LARG_CONT)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetTop (resetTop),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [17:0] exp_q[$];  // {dado_rec, dado_periodo, periodo[15:0]}

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  // ---------------- reference model (crossing times) ----------------
  int t          = 0;
  bit m_armed    = 0;
  int m_last_ev  = 0;
  int m_nev      = 0;   // crossings seen since the last loss of signal (capped at 2)
  int m_run      = 0;   // length of the current run of equal classes
  bit m_last_cls = 0;
  bit m_rec      = 0;

  task automatic model_reset();
    m_armed = 0; m_nev = 0; m_run = 0; m_last_cls = 0; m_rec = 0;
  endtask

  task automatic model_step(input logic [7:0] a, input bit v);
    bit ev;
    bit cls;
    int gap;
    ev = m_armed && v && (int'(a) >= MEIO + HIST);
    if (ev) begin
      m_armed = 0;
      if (m_nev >= 1) begin
        gap = t - m_last_ev;
        cls = (gap < LIMIAR);
        if (m_run > 0 && cls == m_last_cls) m_run = (m_run < CONFIRMA) ? m_run + 1 : m_run;
        else m_run = 1;
        m_last_cls = cls;
        if (m_run >= CONFIRMA) m_rec = cls;
        exp_q.push_back({m_rec, cls, 16'(gap)});
      end
      m_nev = (m_nev >= 2) ? 2 : m_nev + 1;
      m_last_ev = t;
    end else begin
      if (v && int'(a) < MEIO - HIST) m_armed = 1;
      if (m_nev >= 1 && (t - m_last_ev) >= PMAX) begin
        m_nev = 0;
        m_run = 0;
      end
    end
    t++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [7:0] a, input bit v);
    bus.amostra        = a;
    bus.amostra_valida = v;
    model_step(a, v);
    @(negedge CLOCK_50);
  endtask

  function automatic logic [7:0] tri_val(input int p, input int per, input bit ruido);
    int v;
    if (p < per / 2) v = (p * 510) / per;
    else v = ((per - p) * 510) / per;
    if (ruido) v = v + int'($urandom_range(0, 10)) - 5;
    if (v > 255) v = 255;
    if (v < 0) v = 0;
    return 8'(v);
  endfunction

  task automatic run_wave(input int per, input int n, input bit ruido, input bit falhas);
    bit v;
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < per; p++) begin
        v = falhas ? ($urandom_range(0, 7) != 0) : 1'b1;
        step(tri_val(p, per, ruido), v);
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_travado"}, 32'(bus.travado), 32'(m_nev >= 2));
    check({tag, "_sem_sinal"}, 32'(bus.sem_sinal), 32'(m_nev < 2));
    check({tag, "_dado_rec"}, 32'(bus.dado_rec), 32'(m_rec));
  endtask

  task automatic async_reset_mid();
    @(posedge CLOCK_50);
    #3 resetTop = 1'b1;
    #1;
    check("rst_mid_dado_rec", 32'(bus.dado_rec), 32'd0);
    check("rst_mid_sem_sinal", 32'(bus.sem_sinal), 32'd1);
    check("rst_mid_travado", 32'(bus.travado), 32'd0);
    check("rst_mid_periodo", 32'(bus.periodo), 32'd0);
    check("rst_mid_dado_valido", 32'(bus.dado_valido), 32'd0);
    @(negedge CLOCK_50);
    bus.amostra = 8'd0;
    bus.amostra_valida = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    resetTop = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge CLOCK_50);
      if (!resetTop && bus.dado_valido) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL report_extra: got periodo %0d expected no report", bus.periodo);
        end else begin
          e = exp_q.pop_front();
          check("periodo", 32'(bus.periodo), 32'(e[15:0]));
          check("dado_periodo", 32'(bus.dado_periodo), 32'(e[16]));
          check("dado_rec", 32'(bus.dado_rec), 32'(e[17]));
          check("travado_no_report", 32'(bus.travado), 32'd1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int per_tab[6];
    per_tab = '{96, 128, 160, 200, 256, 300};
    resetTop = 1'b1;
    bus.amostra = 8'd0;
    bus.amostra_valida = 1'b0;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    check("rst_dado_rec", 32'(bus.dado_rec), 32'd0);
    check("rst_dado_valido", 32'(bus.dado_valido), 32'd0);
    check("rst_dado_periodo", 32'(bus.dado_periodo), 32'd0);
    check("rst_periodo", 32'(bus.periodo), 32'd0);
    check("rst_travado", 32'(bus.travado), 32'd0);
    check("rst_sem_sinal", 32'(bus.sem_sinal), 32'd1);
    resetTop = 1'b0;

    // lock on the short period, then switch to the long one
    run_wave(128, 6, 1'b0, 1'b0);
    check_status("lock128");
    run_wave(256, 4, 1'b0, 1'b0);
    check_status("lock256");

    // a single long period inside a short stream
    run_wave(128, 4, 1'b0, 1'b0);
    run_wave(256, 1, 1'b0, 1'b0);
    run_wave(128, 4, 1'b0, 1'b0);
    check_status("isolado");

    // flat mid-scale input until loss of signal, then relock
    repeat (4200) step(8'd128, 1'b1);
    check_status("perda");
    run_wave(128, 3, 1'b0, 1'b0);
    check_status("relock");

    // asynchronous reset in the middle of a period
    run_wave(128, 2, 1'b0, 1'b0);
    for (int p = 0; p < 100; p++) step(tri_val(p, 128, 1'b0), 1'b1);
    async_reset_mid();
    run_wave(128, 1, 1'b0, 1'b0);
    check_status("pos_rst_1cruz");
    run_wave(128, 2, 1'b0, 1'b0);
    check_status("pos_rst_lock");

    // noise within the hysteresis band riding on the wave
    run_wave(128, 6, 1'b1, 1'b0);
    check_status("ruido");

    // random periods, noise and dropped samples
    repeat (25) begin
      run_wave(per_tab[$urandom_range(0, 5)], int'($urandom_range(1, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (10) step(8'd0, 1'b1);
    check_status("final");
    check("fila_vazia", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/detector_senoide.md
Name: detector_senoide

Overview:
- Receive-side counterpart of the sine generator: recovers the modulating bit `dado` from the generator's 8-bit unsigned sample stream.
- Modulation is FSK: `dado`=1 gives a shorter sine period, `dado`=0 a longer one.
- Method: detect rising mid-scale crossings with hysteresis, measure cycles between crossings, classify each period, then debounce the class into a stable recovered bit.
- Sits in the receive path, fed directly by the generator's sample bus (loopback) or by an ADC.

Parameters:
- MEIO, 128, mid-scale code of the unsigned sample.
- HIST, 8, hysteresis half-width in codes.
- LIMIAR_PERIODO, 192, periods (clocks) strictly below this classify as 1, otherwise 0.
- PERIODO_MAX, 4096, clocks without a crossing before declaring loss of signal.
- CONFIRMA, 2, consecutive equal classifications required to change `dado_rec`.
- LARG_CONT, 16, period counter width; must satisfy 2^LARG_CONT > PERIODO_MAX.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- resetTop  in  1  reset, asynchronous and active-high.
- amostra  in  8  unsigned sine sample.
- amostra_valida  in  1  sample qualifier; when 0 the sample is ignored but counters still run.
- dado_rec  out  1  debounced recovered bit.
- dado_valido  out  1  one-cycle pulse per classified period.
- dado_periodo  out  1  raw class of the period just measured; meaningful when `dado_valido`=1.
- periodo  out  LARG_CONT  last measured period in clocks.
- travado  out  1  locked: at least one full period measured since the last loss of signal.
- sem_sinal  out  1  loss of signal.

Behaviour:
- Reset (async, any time, including mid-period):
  - All outputs 0, except `sem_sinal`=1.
  - Counter 0, armed flag 0, confirmation counter 0, state BUSCA.
- Input register:
  - `amostra`/`amostra_valida` are registered once; all detection uses the registered copy (1-cycle input latency).
- Armed flag:
  - Set when the registered sample is valid and < MEIO-HIST.
- Crossing event `ev`:
  - Fires when armed and the registered sample is valid and >= MEIO+HIST.
  - Clears the armed flag in the same cycle.
  - Samples between the two thresholds change nothing.
- Counter:
  - Increments every clock, saturating at 2^LARG_CONT-1.
  - On `ev` it loads 1, so period = cycles between consecutive events.
- FSM states: BUSCA, PRIMEIRO, MEDINDO.
  - BUSCA: `sem_sinal`=1, `travado`=0. On `ev` go to PRIMEIRO; no period is reported.
  - PRIMEIRO: on `ev`, report the period, set `travado`=1, clear `sem_sinal`, go to MEDINDO.
  - MEDINDO: on each `ev`, report the period.
  - PRIMEIRO and MEDINDO: if the counter reaches PERIODO_MAX without `ev`, go to BUSCA, set `sem_sinal`=1, clear `travado`, clear the confirmation counter. `dado_rec` holds its value.
- Report (registered, 1 cycle after `ev`):
  - `periodo` takes the counter value.
  - `dado_periodo` = (count < LIMIAR_PERIODO).
  - `dado_valido` pulses 1 for exactly one cycle.
- Debounce:
  - On a report, if the class equals the previous class, the confirmation counter increments (saturating); otherwise it is set to 1.
  - When the counter reaches CONFIRMA and the class differs from `dado_rec`, `dado_rec` updates in the same cycle as the `dado_valido` pulse.
- Timeout and `ev` in the same cycle: `ev` wins (report, no timeout).
- Total latency: crossing sample at input edge N → `dado_valido` at edge N+2.

Optional Feature:
- Macro DETECTOR_SENOIDE_AMPLITUDE_EN, when defined:
  - Adds output `pico` [7:0]: the maximum valid sample seen during the last complete period.
  - `pico` is updated together with `periodo`.
  - A running maximum resets to the current sample on `ev`.
  - `pico` resets to 0.
- When undefined: no `pico` port and no amplitude logic.

Decomposition:
- Shared package `senoide_pkg`:
  - FSM enum `estado_det_t` {BUSCA, PRIMEIRO, MEDINDO}.
  - Sample width constant (8).
  - Default MEIO/HIST constants, also used by the generator.
- Sub-module `detector_cruzamento`: input register, armed flag, `ev` output. The top holds the FSM, counter, and debounce.

Test Plan:
- Reset mid-period: assert `resetTop` asynchronously between clock edges during MEDINDO → outputs clear immediately, `sem_sinal`=1; after release, `travado` only after two crossings.
- Triangle wave 0→255→0, period 128, continuous → first `dado_valido` after the second crossing with `periodo`=128 and `dado_periodo`=1; `dado_rec`=1 at the second report.
- Switch the wave period 128→256 → first 256 report has `dado_periodo`=0 with `dado_rec` still 1; the next report sets `dado_rec`=0.
- Single 256 period inside a 128 stream → `dado_periodo`=0 once, `dado_rec` stays 1.
- Constant input 128 after lock → after 4096 clocks `sem_sinal`=1, `travado`=0, `dado_rec` held.
- Noise of ±5 codes around 128 riding on the wave → no extra `ev`; `periodo` stays 128.
